// File: rtl/alu_cmd_sequencer_if.sv
// Bus between the command sequencer and its environment (UART rx/tx and ALU).
// Names keep the sequencer's point of view: i_* flow into it, o_* flow out of it.
interface alu_cmd_sequencer_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
);
  // rx_done and tx_done are one-cycle strobes with no back-pressure: a byte is
  // offered exactly in the cycle rx_done is high, and tx_start is a one-cycle
  // request that the transmitter must accept; tx_data stays stable until tx_done.
  logic             i_rx_done;
  logic [DBIT-1:0]  i_rx_data;
  logic [DBIT-1:0]  i_alu_result;
  logic             i_tx_done;
  logic [DBIT-1:0]  o_data_a;
  logic [DBIT-1:0]  o_data_b;
  logic [NB_OP-1:0] o_op;
  logic             o_tx_start;
  logic [DBIT-1:0]  o_tx_data;
  logic             o_busy;
  logic             o_timeout;
  logic             o_overrun;
  logic [2:0]       o_state;

  modport slave (
    input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_op, o_tx_start, o_tx_data,
           o_busy, o_timeout, o_overrun, o_state
  );

  modport master (
    output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_tx_start, o_tx_data,
           o_busy, o_timeout, o_overrun, o_state
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Collects operand A, operand B and opcode bytes, runs the ALU, sends the result.
// Optional opcode screening with CMD_OP_CHECK_EN (invalid opcodes answer ERR_CODE).
module alu_cmd_sequencer #(
  parameter int              DBIT           = 8,
  parameter int              NB_OP          = 6,
  parameter int              NB_TIMEOUT     = 20,
  parameter int              TIMEOUT_CYCLES = 1000000,
  parameter logic [DBIT-1:0] ERR_CODE       = 8'hEE
) (
  input logic                 i_clock,
  input logic                 i_reset,
  alu_cmd_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                state, state_next;
  logic [NB_TIMEOUT-1:0] cnt;
  logic [DBIT-1:0]       data_a, data_b, tx_data;
  logic [NB_OP-1:0]      op;
  logic                  timeout_q, overrun_q;
  logic                  load_a, load_b, load_op, load_tx;
  logic                  cnt_inc, timeout_set, overrun_set;
  logic                  expire, op_ok, op_err;

  assign expire = (cnt == CNT_LAST);

`ifdef CMD_OP_CHECK_EN
  function automatic logic op_valid(input logic [NB_OP-1:0] code);
    case (code)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010):
        op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  endfunction

  assign op_ok = op_valid(bus.i_rx_data[NB_OP-1:0]);

  // Remembers that the latched command was rejected so EXEC answers ERR_CODE.
  always_ff @(posedge i_clock) begin
    if (!i_reset)    op_err <= 1'b0;
    else if (load_op) op_err <= !op_ok;
  end
`else
  assign op_ok  = 1'b1;
  assign op_err = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_op     = 1'b0;
    load_tx     = 1'b0;
    cnt_inc     = 1'b0;
    timeout_set = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_rx_done) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.i_rx_done) begin
          load_b     = 1'b1;
          state_next = WAIT_OP;
        end else if (expire) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_OP: begin
        if (bus.i_rx_done) begin
          load_op    = 1'b1;
          state_next = EXEC;
        end else if (expire) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      EXEC: begin
        load_tx     = 1'b1;
        overrun_set = bus.i_rx_done;
        state_next  = SEND;
      end
      SEND: begin
        overrun_set = bus.i_rx_done;
        state_next  = WAIT_TX;
      end
      WAIT_TX: begin
        overrun_set = bus.i_rx_done;
        if (bus.i_tx_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter only runs while waiting for B or opcode; every other path clears it.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      cnt       <= '0;
      data_a    <= '0;
      data_b    <= '0;
      op        <= '0;
      tx_data   <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt       <= cnt_inc ? cnt + 1'b1 : '0;
      timeout_q <= timeout_set;
      overrun_q <= overrun_set;
      if (load_a)           data_a  <= bus.i_rx_data;
      if (load_b)           data_b  <= bus.i_rx_data;
      if (load_op && op_ok) op      <= bus.i_rx_data[NB_OP-1:0];
      if (load_tx)          tx_data <= op_err ? ERR_CODE : bus.i_alu_result;
    end
  end

  assign bus.o_data_a   = data_a;
  assign bus.o_data_b   = data_b;
  assign bus.o_op       = op;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_start = (state == SEND);
  assign bus.o_busy     = (state == EXEC) || (state == SEND) || (state == WAIT_TX);
  assign bus.o_timeout  = timeout_q;
  assign bus.o_overrun  = overrun_q;
  assign bus.o_state    = state;

endmodule
